// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Purely combinational one-bit full adder cell.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, one bit per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cry;
  logic             load_c;
  logic             last_c;
  logic             fa_sum;
  logic             fa_cout;

  // Operands are shifted right each RUN cycle, so bit[cnt] is always at index 0.
  fa_bit u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (cry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load_c  = 1'b0;
    last_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          load_c  = 1'b1;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          state_n = DONE;
          last_c  = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_n = RUN;
          load_c  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      cry       <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_n == RUN);
      done <= (state_n == DONE);
      if (load_c) begin
        cnt <= '0;
        opa <= a;
        opb <= sub ? ~b : b;
        cry <= sub ? 1'b1 : cin;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        opa <= {1'b0, opa[WIDTH-1:1]};
        opb <= {1'b0, opb[WIDTH-1:1]};
        cry <= fa_cout;
        sum <= {fa_sum, sum[WIDTH-1:1]};
        if (last_c) begin
          carry_out <= fa_cout;
          overflow  <= cry ^ fa_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 2 and 32.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          sub = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          busy, done, carry_out, overflow;
  logic [W-1:0]  sum;

  logic          start2 = 1'b0;
  logic [1:0]    a2 = '0, b2 = '0;
  logic          busy2, done2, co2, ov2;
  logic [1:0]    sum2;

  logic          start32 = 1'b0;
  logic [31:0]   a32 = '0, b32 = '0;
  logic          busy32, done32, co32, ov32;
  logic [31:0]   sum32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(1'b0), .a(a2), .b(b2), .cin(1'b0),
    .busy(busy2), .done(done2), .sum(sum2), .carry_out(co2), .overflow(ov2)
  );

  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .sub(1'b0), .a(a32), .b(b32), .cin(1'b0),
    .busy(busy32), .done(done32), .sum(sum32), .carry_out(co32), .overflow(ov32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {carry_out, overflow, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic         ov;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + (W+1)'(s ? 1'b1 : ci);
    ov   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {full[W], ov, full[W-1:0]};
  endfunction

  // One full operation with latency, handshake and result checks.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s, input string nm);
    logic [W+1:0] exp;
    logic         ok;
    exp   = model(x, y, ci, s);
    a     = x;
    b     = y;
    cin   = ci;
    sub   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~x;
    b     = ~y;
    ok    = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s busy_window: busy/done not busy=1,done=0 for %0d cycles", nm, W);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle: done=%b busy=%b required done=1 busy=0", nm, done, busy);
    end
    checks++;
    if ({carry_out, overflow, sum} !== exp) begin
      errors++;
      $display("FAIL %s result: co=%b ov=%b sum=%h required co=%b ov=%b sum=%h (a=%h b=%h cin=%b sub=%b)",
               nm, carry_out, overflow, sum, exp[W+1], exp[W], exp[W-1:0], x, y, ci, s);
    end
    tick();
    checks++;
    if (done !== 1'b0 || {carry_out, overflow, sum} !== exp) begin
      errors++;
      $display("FAIL %s hold: done=%b sum=%h required done=0 sum=%h", nm, done, sum, exp[W-1:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, carry_out, overflow, sum} !== '0 || busy2 !== 1'b0 || busy32 !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b co=%b ov=%b sum=%h required all zero",
               busy, done, carry_out, overflow, sum);
    end
    start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, "add_5a_33");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_wrap");
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, "add_wrap_cin");
    run_op(8'h10, 8'h20, 1'b1, 1'b1, "sub_borrow");
    run_op(8'h80, 8'h01, 1'b0, 1'b1, "sub_overflow");
    // Plan-stated constants, independent of the model function.
    checks++;
    if (sum !== 8'h7F || carry_out !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sub_80_01_const: sum=%h co=%b ov=%b required 7f 1 1", sum, carry_out, overflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_ignore_start();
    logic [W+1:0] exp;
    int           ndone;
    exp   = model(8'hC3, 8'h5E, 1'b1, 1'b0);
    a     = 8'hC3;
    b     = 8'h5E;
    cin   = 1'b1;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < int'(W) + 4; i++) begin
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if ({carry_out, overflow, sum} !== exp) begin
          errors++;
          $display("FAIL ignore_start result: sum=%h co=%b required sum=%h co=%b",
                   sum, carry_out, exp[W-1:0], exp[W+1]);
        end
      end
      tick();
    end
    checks++;
    if (ndone != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start pulses: done pulses=%0d busy=%b required 1 and 0", ndone, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] e1, e2;
    e1    = model(8'h12, 8'h34, 1'b0, 1'b0);
    e2    = model(8'h40, 8'h41, 1'b0, 1'b1);
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    a     = 8'h40;
    b     = 8'h41;
    sub   = 1'b1;
    for (int i = 0; i < int'(W); i++) tick();
    checks++;
    if (done !== 1'b1 || {carry_out, overflow, sum} !== e1) begin
      errors++;
      $display("FAIL b2b first: done=%b sum=%h required done=1 sum=%h", done, sum, e1[W-1:0]);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b reaccept: busy=%b done=%b required busy=1 done=0", busy, done);
    end
    for (int i = 0; i < int'(W); i++) tick();
    checks++;
    if (done !== 1'b1 || {carry_out, overflow, sum} !== e2) begin
      errors++;
      $display("FAIL b2b second: done=%b sum=%h co=%b required done=1 sum=%h co=%b",
               done, sum, carry_out, e2[W-1:0], e2[W+1]);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int ndone;
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, carry_out, overflow, sum} !== '0) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b co=%b ov=%b sum=%h required all zero",
               busy, done, carry_out, overflow, sum);
    end
    ndone = 0;
    for (int i = 0; i < int'(W) + 3; i++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      tick();
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL abort_quiet: busy/done seen %0d cycles required 0", ndone);
    end
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_rst_start();
    a     = 8'h01;
    b     = 8'h01;
    start = 1'b1;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start: busy=%b required 0", busy);
    end
    tick();
  endtask

  task automatic test_widths();
    int n;
    a2     = 2'b11;
    b2     = 2'b01;
    start2 = 1'b1;
    n      = 0;
    do begin
      tick();
      start2 = 1'b0;
      n++;
    end while (done2 !== 1'b1 && n < 50);
    checks++;
    if (n != 3 || sum2 !== 2'b00 || co2 !== 1'b1) begin
      errors++;
      $display("FAIL width2: latency=%0d sum=%b co=%b required 3 00 1", n, sum2, co2);
    end
    a32     = 32'hFFFF_FFFF;
    b32     = 32'h1;
    start32 = 1'b1;
    n       = 0;
    do begin
      tick();
      start32 = 1'b0;
      n++;
    end while (done32 !== 1'b1 && n < 80);
    checks++;
    if (n != 33 || sum32 !== 32'h0 || co32 !== 1'b1) begin
      errors++;
      $display("FAIL width32: latency=%0d sum=%h co=%b required 33 0 1", n, sum32, co32);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_rst_start();
    test_widths();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
